aes128_encrypt_iter: RTL and testbench

//  Iterative AES-128 forward cipher (FIPS-197) that computes one round per clock.
//  It is the encrypt-direction counterpart of the inverse datapath in this tree.
//  It applies forward ShiftRows, SubBytes, MixColumns and AddRoundKey, and expands the key on the fly.
//  It sits between the I2C register front-end and the ciphertext readback registers.

---
 rtl/aes128_encrypt_iter.sv | 222 ++++++++++++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional AES_ENC_LAST_KEY_EN adds a last_key output holding round key 10.
module aes128_encrypt_iter #(
    parameter bit CLEAR_ON_POP = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out,
    output logic         busy
`ifdef AES_ENC_LAST_KEY_EN
    ,
    output logic [127:0] last_key
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } fsm_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         out_valid_q, out_valid_d;

    logic [7:0]   sb [16];
    logic [127:0] sr_flat;
    logic [127:0] mc_flat;
    logic [31:0]  sub_word;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [127:0] rkey_next;
    logic [127:0] round_out;

    // Byte i of the state lives at [127-8*i -: 8]; column c is bytes 4c..4c+3.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            sb[i] = sbox(state_q[127-8*i -: 8]);
        end
    end

    always_comb begin
        sr_flat = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr_flat[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
            end
        end
    end

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mc_flat = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = sr_flat[127-32*c -: 8];
            a1 = sr_flat[119-32*c -: 8];
            a2 = sr_flat[111-32*c -: 8];
            a3 = sr_flat[103-32*c -: 8];
            mc_flat[127-32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
    end

    // SubWord(RotWord(w3)): rotation moves the top byte to the bottom.
    always_comb begin
        sub_word  = {sbox(rkey_q[23:16]), sbox(rkey_q[15:8]), sbox(rkey_q[7:0]), sbox(rkey_q[31:24])};
        w0_n      = rkey_q[127:96] ^ sub_word ^ {rcon(rnd_q), 24'h0};
        w1_n      = rkey_q[95:64] ^ w0_n;
        w2_n      = rkey_q[63:32] ^ w1_n;
        w3_n      = rkey_q[31:0] ^ w2_n;
        rkey_next = {w0_n, w1_n, w2_n, w3_n};
        round_out = ((rnd_q == 4'd10) ? sr_flat : mc_flat) ^ rkey_next;
    end

`ifdef AES_ENC_LAST_KEY_EN
    logic [127:0] last_key_q, last_key_d;
`endif

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rkey_d      = rkey_q;
        ct_d        = ct_q;
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
`ifdef AES_ENC_LAST_KEY_EN
        last_key_d  = last_key_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = pt_in ^ key_in;
                    rkey_d  = key_in;
                    rnd_d   = 4'd1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = round_out;
                rkey_d  = rkey_next;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == 4'd10) begin
                    rnd_d       = 4'd0;
                    ct_d        = round_out;
                    out_valid_d = 1'b1;
                    fsm_d       = S_DONE;
`ifdef AES_ENC_LAST_KEY_EN
                    last_key_d  = rkey_next;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = S_IDLE;
                    if (CLEAR_ON_POP) begin
                        ct_d       = '0;
                        state_d    = '0;
                        rkey_d     = '0;
`ifdef AES_ENC_LAST_KEY_EN
                        last_key_d = '0;
`endif
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            rkey_q      <= '0;
            ct_q        <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rkey_q      <= rkey_d;
            ct_q        <= ct_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef AES_ENC_LAST_KEY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key_q <= '0;
        end else begin
            last_key_q <= last_key_d;
        end
    end

    assign last_key = last_key_q;
`endif

    assign in_ready  = (fsm_q == S_IDLE);
    assign busy      = (fsm_q == S_ROUND) || (fsm_q == S_DONE);
    assign out_valid = out_valid_q;
    assign ct_out    = ct_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: FIPS-197 vectors, handshake corner
// cases and random blocks against a reference built from GF(2^8) arithmetic.
module tb_aes128_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] pt_in = '0;
    logic [127:0] key_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] ct_out;
    logic         busy;
`ifdef AES_ENC_LAST_KEY_EN
    logic [127:0] last_key;
`endif

    aes128_encrypt_iter #(.CLEAR_ON_POP(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt_in     (pt_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_out    (ct_out),
        .busy      (busy)
`ifdef AES_ENC_LAST_KEY_EN
        ,
        .last_key  (last_key)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [127:0] V1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V2_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int total = 0;
    int bad = 0;
    logic [7:0] sbox_tab [256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from multiplicative inverse plus affine map, independent of any table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key,
                                             input bit want_last_key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sbox_tab[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = (rnd == 10) ? t[4*c+r] :
                               gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                               ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        if (want_last_key) res = {w[40], w[41], w[42], w[43]};
        return res;
    endfunction

    // Called at a negedge while IDLE; returns just after the accept edge with inputs scrambled.
    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        check("ready_before_send", 128'(in_ready), 128'(1));
        pt_in = pt;
        key_in = key;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pt_in = {$urandom, $urandom, $urandom, $urandom};
        key_in = {$urandom, $urandom, $urandom, $urandom};
        check("busy_after_accept", {126'(0), busy, in_ready}, 128'b10);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    // Called at a negedge with out_valid high; ends at the following negedge.
    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("pop_flags", {125'(0), out_valid, in_ready, busy}, 128'b010);
        check("pop_ct_cleared", ct_out, 128'h0);
    endtask

    initial begin
        int lat;
        int last_cyc;
        int outs;
        int k;
        logic [127:0] rp;
        logic [127:0] rk;
        logic [127:0] exp_q[$];
        logic [127:0] vec_pt [2];
        logic [127:0] vec_key [2];
        logic [127:0] vec_ct [2];

        build_sbox();
        repeat (2) @(negedge clk);
        check("reset_flags", {125'(0), out_valid, in_ready, busy}, 128'b010);
        check("reset_ct", ct_out, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 App.B with latency and backpressure
        send(V1_PT, V1_KEY);
        wait_out(lat);
        check("v1_latency", 128'(lat), 128'(10));
        check("v1_ct", ct_out, V1_CT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_flags", {125'(0), out_valid, in_ready, busy}, 128'b101);
            check("hold_ct", ct_out, V1_CT);
        end
        pop();

        // FIPS-197 App.C.1
        send(V2_PT, V2_KEY);
        wait_out(lat);
        check("v2_latency", 128'(lat), 128'(10));
        check("v2_ct", ct_out, V2_CT);
`ifdef AES_ENC_LAST_KEY_EN
        check("v2_last_key", last_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
`endif
        pop();

        // Vector 2 offered throughout vector 1's rounds is only taken after the pop
        pt_in = V1_PT;
        key_in = V1_KEY;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        pt_in = V2_PT;
        key_in = V2_KEY;
        wait_out(lat);
        check("busy_ignore_ct", ct_out, V1_CT);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_pop", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("second_accept", 128'(busy), 128'(1));
        wait_out(lat);
        check("second_latency", 128'(lat), 128'(10));
        check("second_ct", ct_out, V2_CT);
        pop();

        // Asynchronous reset in round 5, then a clean rerun
        send(V1_PT, V1_KEY);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_flags", {125'(0), out_valid, in_ready, busy}, 128'b010);
        check("midreset_ct", ct_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(V1_PT, V1_KEY);
        wait_out(lat);
        check("rerun_ct", ct_out, V1_CT);
        pop();

        // Random blocks against the reference model
        for (int n = 0; n < 12; n++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rp, rk);
            wait_out(lat);
            check("rand_latency", 128'(lat), 128'(10));
            check("rand_ct", ct_out, aes_ref(rp, rk, 1'b0));
`ifdef AES_ENC_LAST_KEY_EN
            check("rand_last_key", last_key, aes_ref(rp, rk, 1'b1));
`endif
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pop();
        end

        // Back-to-back: each block spends one IDLE, ten ROUND and one DONE cycle
        vec_pt[0] = V1_PT;  vec_key[0] = V1_KEY; vec_ct[0] = V1_CT;
        vec_pt[1] = V2_PT;  vec_key[1] = V2_KEY; vec_ct[1] = V2_CT;
        out_ready = 1'b1;
        in_valid = 1'b1;
        k = 0;
        outs = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) check("b2b_ct", ct_out, exp_q.pop_front());
                if (last_cyc >= 0) check("b2b_period", 128'(cyc - last_cyc), 128'(12));
                last_cyc = cyc;
                outs++;
            end
            if (in_ready) begin
                pt_in = vec_pt[k % 2];
                key_in = vec_key[k % 2];
                exp_q.push_back(vec_ct[k % 2]);
                k++;
            end
            @(negedge clk);
        end
        check("b2b_count", 128'(outs), 128'(5));
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
